register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file for the MIPS core: 32 x 32-bit GPRs, two combinational read ports, one synchronous write port.
- Sits between decode (reads rs/rt) and writeback (writes rd/rt). It is the read side of the per-register load/out interface.
- Includes a pending-write scoreboard. Decode reserves a destination when a multi-cycle load issues. Readers see a busy flag until writeback lands.
- $zero is hardwired to 0 and is never busy.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all registers and busy bits
read_addr1  input  ADDR_WIDTH  port 1 register index (rs)
read_data1  output  DATA_WIDTH  port 1 value
read_busy1  output  1  port 1 register has a pending write
read_addr2  input  ADDR_WIDTH  port 2 register index (rt)
read_data2  output  DATA_WIDTH  port 2 value
read_busy2  output  1  port 2 register has a pending write
write_enable  input  1  commit write_data to write_addr this edge
write_addr  input  ADDR_WIDTH  writeback destination
write_data  input  DATA_WIDTH  writeback value
reserve_enable  input  1  mark reserve_addr busy (load issued)
reserve_addr  input  ADDR_WIDTH  register to reserve

Behaviour:
- One clock, named clock. Reset is named reset, is synchronous and active-high, and takes priority over every other input on that edge.
- Reset effect: all 32 registers become 0 and all busy bits clear. From the cycle after reset, every read returns data 0 and busy 0.
- Write: on a rising edge with write_enable=1 and write_addr!=0, regs[write_addr] <= write_data. Writes to index 0 are dropped.
- Read: combinational with zero latency.
  - Index 0 always gives data 0, busy 0.
  - Otherwise the port returns regs[addr].
- Write-through bypass: if write_enable=1, write_addr==read_addrN and read_addrN!=0, read_dataN = write_data in that same cycle. Decode therefore sees the writeback value without a 1-cycle hazard.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Write edge (write_enable=1, addr!=0): busy[write_addr] <= 0.
  - Reserve edge (reserve_enable=1, addr!=0): busy[reserve_addr] <= 1.
  - Same address, same edge for both: reserve wins and the bit ends at 1, because a newer load is in flight. The data write still commits.
  - Reserving an already-busy register leaves it busy (idempotent).
- read_busyN:
  - Normally the stored busy[read_addrN].
  - Forced to 0 when a bypassing write to that address occurs the same cycle, because the data is valid now.
  - A same-cycle reserve does not raise busy until the next cycle.
- Both read ports may address the same register; they return identical data and busy.
- Reset asserted while busy bits are set or a write is presented: reset wins, the write is lost and busy is cleared.
- No X on outputs for any in-range address after the first reset edge.

Decomposition:
- Shared defines file holds:
  - REG_ZERO = 0, REG_RA = 31
  - GPR_COUNT = 32, DATA_WIDTH and ADDR_WIDTH defaults
- These are shared with decode and writeback.
- One sub-module: register_scoreboard.
  - Holds the busy-bit vector, reserve/clear priority and reset.
  - Exposes two combinational busy lookups.
  - Used so that hazard logic can be verified standalone.
- The data array stays in register_file.

Test Plan:
- Reset, then read addr 0..31 on both ports -> all read_data=0, read_busy=0.
- Write 0xDEADBEEF to r8 (write_enable=1 one edge); next cycle read_addr1=8 -> 0xDEADBEEF. Write 0x0000BABE to r0; read_addr2=0 -> 0x00000000.
- Bypass check:
  - r9 holds 0x11111111.
  - In the same cycle, drive write r9=0x1111BABE and read_addr1=9, read_addr2=9.
  - Both data outputs = 0x1111BABE before the edge, and still after it.
- Reserve r4 -> next cycle read_busy1=1 (addr 4). Write r4=0x12345678 -> read_busy1=0 combinationally that cycle, data=0x12345678; after the edge busy stays 0.
- Reserve and write r5 on the same edge (data 0xCAFEF00D) -> after the edge busy[5]=1 and regs[5]=0xCAFEF00D. Reserve r0 -> read_busy for addr 0 stays 0.
- Reserve r6, then assert reset together with write r6=0xFFFFFFFF -> after the edge read r6 gives data 0, busy 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared register-file constants used by decode, writeback and the register file itself.
package register_file_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned GPR_COUNT  = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 31;

    // Scoreboard update request, decoded once per edge.
    typedef struct packed {
        logic                  clear;
        logic                  set;
        logic [ADDR_WIDTH-1:0] clear_addr;
        logic [ADDR_WIDTH-1:0] set_addr;
    } sb_req_t;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side bus of the register file: two read ports, one write port, one reserve port.
interface register_file_if #(
    parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [DATA_WIDTH-1:0] read_data1;
    logic                  read_busy1;

    logic [ADDR_WIDTH-1:0] read_addr2;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  read_busy2;

    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  reserve_enable;
    logic [ADDR_WIDTH-1:0] reserve_addr;

    modport master (
        output read_addr1,
        output read_addr2,
        output write_enable,
        output write_addr,
        output write_data,
        output reserve_enable,
        output reserve_addr,
        input  read_data1,
        input  read_busy1,
        input  read_data2,
        input  read_busy2
    );

    modport slave (
        input  read_addr1,
        input  read_addr2,
        input  write_enable,
        input  write_addr,
        input  write_data,
        input  reserve_enable,
        input  reserve_addr,
        output read_data1,
        output read_busy1,
        output read_data2,
        output read_busy2
    );

endinterface

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR, set by load issue, cleared by writeback.
module register_scoreboard
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic                  reserve_enable_i,
    input  logic [ADDR_WIDTH-1:0] reserve_addr_i,

    input  logic [ADDR_WIDTH-1:0] lookup_addr1_i,
    output logic                  lookup_busy1_o,
    input  logic [ADDR_WIDTH-1:0] lookup_addr2_i,
    output logic                  lookup_busy2_o
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    sb_req_t          req;

    always_comb begin
        req            = '0;
        req.clear      = write_enable_i && (write_addr_i != ZERO_ADDR);
        req.set        = reserve_enable_i && (reserve_addr_i != ZERO_ADDR);
        req.clear_addr = write_addr_i;
        req.set_addr   = reserve_addr_i;
    end

    // Set is applied after clear so a same-edge reserve wins: a newer load is in flight.
    always_comb begin
        busy_d = busy_q;
        if (req.clear) begin
            busy_d[req.clear_addr] = 1'b0;
        end
        if (req.set) begin
            busy_d[req.set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A bypassing writeback makes the data valid this cycle, so busy is masked.
    always_comb begin
        lookup_busy1_o = 1'b0;
        if (lookup_addr1_i != ZERO_ADDR) begin
            lookup_busy1_o = busy_q[lookup_addr1_i]
                             && !(req.clear && (req.clear_addr == lookup_addr1_i));
        end
    end

    always_comb begin
        lookup_busy2_o = 1'b0;
        if (lookup_addr2_i != ZERO_ADDR) begin
            lookup_busy2_o = busy_q[lookup_addr2_i]
                             && !(req.clear && (req.clear_addr == lookup_addr2_i));
        end
    end

endmodule

// File: rtl/register_file.sv
// MIPS GPR file: 32 x 32-bit, two combinational read ports with write-through bypass,
// one synchronous write port, and a pending-write scoreboard.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    register_file_if.slave  bus
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  write_valid;

    assign write_valid = bus.write_enable && (bus.write_addr != ZERO_ADDR);

    always_comb begin
        regs_d = regs_q;
        if (write_valid) begin
            regs_d[bus.write_addr] = bus.write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: $zero first, then same-cycle writeback, then stored value.
    always_comb begin
        bus.read_data1 = '0;
        if (bus.read_addr1 == ZERO_ADDR) begin
            bus.read_data1 = '0;
        end else if (write_valid && (bus.write_addr == bus.read_addr1)) begin
            bus.read_data1 = bus.write_data;
        end else begin
            bus.read_data1 = regs_q[bus.read_addr1];
        end
    end

    always_comb begin
        bus.read_data2 = '0;
        if (bus.read_addr2 == ZERO_ADDR) begin
            bus.read_data2 = '0;
        end else if (write_valid && (bus.write_addr == bus.read_addr2)) begin
            bus.read_data2 = bus.write_data;
        end else begin
            bus.read_data2 = regs_q[bus.read_addr2];
        end
    end

    register_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clock            (clock),
        .reset            (reset),
        .write_enable_i   (bus.write_enable),
        .write_addr_i     (bus.write_addr),
        .reserve_enable_i (bus.reserve_enable),
        .reserve_addr_i   (bus.reserve_addr),
        .lookup_addr1_i   (bus.read_addr1),
        .lookup_busy1_o   (bus.read_busy1),
        .lookup_addr2_i   (bus.read_addr2),
        .lookup_busy2_o   (bus.read_busy2)
    );

endmodule
